// File: rtl/fp_out_wrapper_ctrl_if.sv
// Result-transmit bus between the FP unit, the output wrapper and the consumer.
// FP_OUT_WRAPPER_PARITY_EN adds the outParity signal.
interface fp_out_wrapper_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                   doneFP;
  logic [WIDTH-1:0]       result;
  logic                   outAccept;
  logic                   outReady;
  logic [WIDTH/2-1:0]     outData;
  logic                   busy;
  logic                   resultSent;
`ifdef FP_OUT_WRAPPER_PARITY_EN
  logic                   outParity;

  modport master (
    output doneFP, result, outAccept,
    input  outReady, outData, busy, resultSent, outParity
  );

  modport slave (
    input  doneFP, result, outAccept,
    output outReady, outData, busy, resultSent, outParity
  );
`else
  modport master (
    output doneFP, result, outAccept,
    input  outReady, outData, busy, resultSent
  );

  modport slave (
    input  doneFP, result, outAccept,
    output outReady, outData, busy, resultSent
  );
`endif
endinterface

// File: rtl/fp_out_wrapper_ctrl.sv
// FP output wrapper: captures the result on doneFP and sends it as two half-words
// (low first) over a 4-phase outReady/outAccept handshake. Option: FP_OUT_WRAPPER_PARITY_EN.
//
// state    | meaning
// IDLE     | no result held, waiting for doneFP
// CAPTURE  | loading result into res_reg
// SEND_LO  | low half presented, waiting for outAccept=1
// WAIT_LO  | low half acknowledged, waiting for outAccept=0
// SEND_HI  | high half presented, waiting for outAccept=1
// WAIT_HI  | high half acknowledged, waiting for outAccept=0
module fp_out_wrapper_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_out_wrapper_ctrl_if.slave  bus
);
  localparam int HALF = WIDTH / 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SEND_LO = 3'd2,
    WAIT_LO = 3'd3,
    SEND_HI = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  res_reg;
  logic              out_ready;
  logic [HALF-1:0]   out_data;
  logic              busy;
  logic              result_sent;
`ifdef FP_OUT_WRAPPER_PARITY_EN
  logic              out_parity;
`endif

  // Outputs are loaded alongside the state transition so they always match the state they enter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      res_reg     <= '0;
      out_ready   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      result_sent <= 1'b0;
`ifdef FP_OUT_WRAPPER_PARITY_EN
      out_parity  <= 1'b0;
`endif
    end else begin
      result_sent <= 1'b0;
      case (state)
        IDLE: begin
          out_ready <= 1'b0;
          out_data  <= '0;
`ifdef FP_OUT_WRAPPER_PARITY_EN
          out_parity <= 1'b0;
`endif
          if (bus.doneFP) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        CAPTURE: begin
          res_reg   <= bus.result;
          out_ready <= 1'b1;
          out_data  <= bus.result[HALF-1:0];
`ifdef FP_OUT_WRAPPER_PARITY_EN
          out_parity <= ^bus.result[HALF-1:0];
`endif
          busy      <= 1'b1;
          state     <= SEND_LO;
        end
        SEND_LO: begin
          out_data <= res_reg[HALF-1:0];
          if (bus.outAccept) begin
            out_ready <= 1'b0;
            state     <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!bus.outAccept) begin
            out_ready <= 1'b1;
            out_data  <= res_reg[WIDTH-1:HALF];
`ifdef FP_OUT_WRAPPER_PARITY_EN
            out_parity <= ^res_reg[WIDTH-1:HALF];
`endif
            state     <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (bus.outAccept) begin
            out_ready <= 1'b0;
            state     <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (!bus.outAccept) begin
            out_data    <= '0;
            busy        <= 1'b0;
            result_sent <= 1'b1;
`ifdef FP_OUT_WRAPPER_PARITY_EN
            out_parity  <= 1'b0;
`endif
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          res_reg     <= '0;
          out_ready   <= 1'b0;
          out_data    <= '0;
          busy        <= 1'b0;
          result_sent <= 1'b0;
`ifdef FP_OUT_WRAPPER_PARITY_EN
          out_parity  <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.outReady   = out_ready;
  assign bus.outData    = out_data;
  assign bus.busy       = busy;
  assign bus.resultSent = result_sent;
`ifdef FP_OUT_WRAPPER_PARITY_EN
  assign bus.outParity  = out_parity;
`endif

endmodule

// File: tb/tb_fp_out_wrapper_ctrl.sv
// Scoreboard bench for fp_out_wrapper_ctrl: stimulus queues expected half-words,
// a negedge monitor pops and compares them as outReady rises.
module tb_fp_out_wrapper_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;

  fp_out_wrapper_ctrl_if #(.WIDTH(32)) bus ();

  fp_out_wrapper_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];
  int sent_cnt = 0;
  int exp_sent = 0;
  logic prev_ready = 1'b0;
  logic [15:0] held_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare each newly presented word and its stability while held.
  always @(negedge clk) begin
    if (bus.resultSent === 1'b1) sent_cnt++;
    if (bus.outReady === 1'b1 && !prev_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 32'(bus.outData), 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("word", 32'(bus.outData), 32'(e));
`ifdef FP_OUT_WRAPPER_PARITY_EN
        chk("parity", 32'(bus.outParity), 32'(^e));
`endif
      end
      held_data = bus.outData;
    end else if (bus.outReady === 1'b1) begin
      chk("word_stable", 32'(bus.outData), 32'(held_data));
    end
    prev_ready = (bus.outReady === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input logic val);
    int n;
    n = 0;
    while (bus.outReady !== val && n < 60) begin
      step();
      n++;
    end
    if (bus.outReady !== val) chk("ready_timeout", 32'(bus.outReady), 32'(val));
  endtask

  task automatic handshake(input int dly);
    wait_ready(1'b1);
    repeat (dly) step();
    bus.outAccept = 1'b1;
    step();
    wait_ready(1'b0);
    repeat (dly) step();
    bus.outAccept = 1'b0;
  endtask

  task automatic issue(input logic [31:0] r);
    exp_q.push_back(r[15:0]);
    exp_q.push_back(r[31:16]);
    bus.result = r;
    bus.doneFP = 1'b1;
    step();
    bus.doneFP = 1'b0;
  endtask

  task automatic finish_transfer();
    step();
    chk("result_sent_pulse", 32'(bus.resultSent), 32'd1);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    exp_sent++;
    step();
    chk("result_sent_once", 32'(bus.resultSent), 32'd0);
  endtask

  initial begin
    bus.doneFP    = 1'b1;
    bus.result    = 32'hFFFF_FFFF;
    bus.outAccept = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.outReady), 32'd0);
    chk("rst_data", 32'(bus.outData), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sent", 32'(bus.resultSent), 32'd0);
    bus.doneFP = 1'b0;
    bus.outAccept = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_ready", 32'(bus.outReady), 32'd0);

    // Basic transfer, fastest consumer.
    issue(32'h3FC0_0000);
    chk("capture_ready", 32'(bus.outReady), 32'd0);
    chk("capture_busy", 32'(bus.busy), 32'd1);
    step();
    chk("latency_ready", 32'(bus.outReady), 32'd1);
    handshake(0);
    handshake(0);
    finish_transfer();

    // Slow consumer.
    issue(32'hC248_ABCD);
    handshake(5);
    handshake(5);
    finish_transfer();
    chk("slow_queue_empty", 32'(exp_q.size()), 32'd0);

    // doneFP during SendHi must not recapture.
    issue(32'h4049_0FDB);
    handshake(1);
    wait_ready(1'b1);
    bus.result = 32'hDEAD_BEEF;
    bus.doneFP = 1'b1;
    step();
    bus.doneFP = 1'b0;
    handshake(1);
    finish_transfer();
    repeat (3) step();
    chk("no_recapture_busy", 32'(bus.busy), 32'd0);
    chk("no_recapture_ready", 32'(bus.outReady), 32'd0);
    chk("illegal_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while in WaitLo.
    exp_q.push_back(16'h5555);
    bus.result = 32'hAAAA_5555;
    bus.doneFP = 1'b1;
    step();
    bus.doneFP = 1'b0;
    wait_ready(1'b1);
    bus.outAccept = 1'b1;
    step();
    chk("waitlo_ready", 32'(bus.outReady), 32'd0);
    chk("waitlo_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ready", 32'(bus.outReady), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_data", 32'(bus.outData), 32'd0);
    bus.outAccept = 1'b0;
    step();
    rst = 1'b1;
    repeat (2) step();
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    issue(32'h1234_5678);
    handshake(0);
    handshake(0);
    finish_transfer();

`ifdef FP_OUT_WRAPPER_PARITY_EN
    issue(32'h0001_0003);
    step();
    chk("parity_lo", 32'(bus.outParity), 32'd0);
    handshake(0);
    wait_ready(1'b1);
    chk("parity_hi", 32'(bus.outParity), 32'd1);
    handshake(0);
    finish_transfer();
    chk("parity_idle", 32'(bus.outParity), 32'd0);
`endif

    repeat (2) step();
    chk("all_words_seen", 32'(exp_q.size()), 32'd0);
    chk("sent_count", 32'(sent_cnt), 32'(exp_sent));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
